// File: rtl/ctrl_pipe_if.sv
// Control-bundle interface between the opcode decoder (master) and ctrl_pipe (slave).
interface ctrl_pipe_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [1:0]       id_alu_op;
  logic             id_alu_src;
  logic             id_mem_2_reg;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             id_mem_write;
  logic             id_branch;
  logic             id_jump;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic [REG_W-1:0] id_rd;
  logic             flush_id_ex;

  logic             stall_if_id;
  logic [1:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic             mem_branch;
  logic             mem_jump;
  logic             wb_mem_2_reg;
  logic             wb_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_alu_op, id_alu_src, id_mem_2_reg, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_rs1, id_rs2, id_rd, flush_id_ex,
    input  stall_if_id, ex_alu_op, ex_alu_src, mem_mem_read, mem_mem_write,
           mem_branch, mem_jump, wb_mem_2_reg, wb_reg_write, wb_rd,
           forward_a, forward_b, bubble_cnt
  );

  modport slave (
    input  id_alu_op, id_alu_src, id_mem_2_reg, id_reg_write, id_mem_read,
           id_mem_write, id_branch, id_jump, id_rs1, id_rs2, id_rd, flush_id_ex,
    output stall_if_id, ex_alu_op, ex_alu_src, mem_mem_read, mem_mem_write,
           mem_branch, mem_jump, wb_mem_2_reg, wb_reg_write, wb_rd,
           forward_a, forward_b, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall, flush bubbles,
// EX-stage forwarding selects and a saturating bubble counter.
module ctrl_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        arst_n,
  ctrl_pipe_if.slave  bus
);

  logic             ex_v, ex_src, ex_m2r, ex_rw, ex_mr, ex_mw, ex_br, ex_j;
  logic [1:0]       ex_op;
  logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;

  logic             mm_v, mm_m2r, mm_rw, mm_mr, mm_mw, mm_br, mm_j;
  logic [REG_W-1:0] mm_rd;

  logic             wb_v, wb_m2r, wb_rw;
  logic [REG_W-1:0] wb_rd_q;

  logic [CNT_W-1:0] cnt;

  logic rs1_used, rs2_used, hazard, bubble;

  assign rs1_used = ~bus.id_jump;
  assign rs2_used = (~bus.id_alu_src & ~bus.id_jump) | bus.id_mem_write;

  assign hazard = ex_v & ex_mr & (ex_rd != '0) &
                  ((rs1_used & (ex_rd == bus.id_rs1)) |
                   (rs2_used & (ex_rd == bus.id_rs2)));

  // Flush already discards the ID instruction, so it must not also hold IF/ID.
  assign bubble          = bus.flush_id_ex | hazard;
  assign bus.stall_if_id = hazard & ~bus.flush_id_ex;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ex_v <= 1'b0; ex_op <= 2'b00; ex_src <= 1'b0; ex_m2r <= 1'b0; ex_rw <= 1'b0;
      ex_mr <= 1'b0; ex_mw <= 1'b0; ex_br <= 1'b0; ex_j <= 1'b0;
      ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
      mm_v <= 1'b0; mm_m2r <= 1'b0; mm_rw <= 1'b0; mm_mr <= 1'b0;
      mm_mw <= 1'b0; mm_br <= 1'b0; mm_j <= 1'b0; mm_rd <= '0;
      wb_v <= 1'b0; wb_m2r <= 1'b0; wb_rw <= 1'b0; wb_rd_q <= '0;
      cnt <= '0;
    end else begin
      if (bubble) begin
        ex_v <= 1'b0; ex_op <= 2'b00; ex_src <= 1'b0; ex_m2r <= 1'b0; ex_rw <= 1'b0;
        ex_mr <= 1'b0; ex_mw <= 1'b0; ex_br <= 1'b0; ex_j <= 1'b0;
        ex_rs1 <= '0; ex_rs2 <= '0; ex_rd <= '0;
      end else begin
        ex_v   <= 1'b1;
        ex_op  <= bus.id_alu_op;
        ex_src <= bus.id_alu_src;
        ex_m2r <= bus.id_mem_2_reg;
        ex_rw  <= bus.id_reg_write;
        ex_mr  <= bus.id_mem_read;
        ex_mw  <= bus.id_mem_write;
        ex_br  <= bus.id_branch;
        ex_j   <= bus.id_jump;
        ex_rs1 <= bus.id_rs1;
        ex_rs2 <= bus.id_rs2;
        ex_rd  <= bus.id_rd;
      end

      mm_v   <= ex_v;
      mm_m2r <= ex_m2r;
      mm_rw  <= ex_rw;
      mm_mr  <= ex_mr;
      mm_mw  <= ex_mw;
      mm_br  <= ex_br;
      mm_j   <= ex_j;
      mm_rd  <= ex_rd;

      wb_v    <= mm_v;
      wb_m2r  <= mm_m2r;
      wb_rw   <= mm_rw;
      wb_rd_q <= mm_rd;

      if (bubble && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.ex_alu_op     = ex_v ? ex_op : 2'b00;
  assign bus.ex_alu_src    = ex_v & ex_src;
  assign bus.mem_mem_read  = mm_v & mm_mr;
  assign bus.mem_mem_write = mm_v & mm_mw;
  assign bus.mem_branch    = mm_v & mm_br;
  assign bus.mem_jump      = mm_v & mm_j;
  assign bus.wb_mem_2_reg  = wb_v & wb_m2r;
  assign bus.wb_reg_write  = wb_v & wb_rw;
  assign bus.wb_rd         = wb_v ? wb_rd_q : '0;
  assign bus.bubble_cnt    = cnt;

  // The younger EX/MEM result takes priority; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_v) begin
      if (mm_v && mm_rw && (mm_rd != '0) && (mm_rd == rs))
        sel = 2'b10;
      else if (wb_v && wb_rw && (wb_rd_q != '0) && (wb_rd_q == rs))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign bus.forward_a = fwd_sel(ex_rs1);
  assign bus.forward_b = fwd_sel(ex_rs2);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: scenario tasks with inline checks plus a
// write-back scoreboard; a second CNT_W=2 instance exercises counter saturation.
module tb_ctrl_pipe;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_2_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  typedef struct {
    int         cyc;
    logic       rw;
    logic       m2r;
    logic [4:0] rd;
  } wb_rec_t;

  logic clk;
  logic arst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   exp_bubbles;
  wb_rec_t wb_q[$];

  ctrl_pipe_if #(.REG_W(5), .CNT_W(16)) bus ();
  ctrl_pipe_if #(.REG_W(5), .CNT_W(2))  bus2 ();

  ctrl_pipe #(.REG_W(5), .CNT_W(16)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  ctrl_pipe #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic instr_t mk_alu_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    instr_t t;
    t = '0;
    t.alu_op = 2'b10; t.reg_write = 1'b1;
    t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    return t;
  endfunction

  function automatic instr_t mk_alu_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2f);
    instr_t t;
    t = mk_alu_r(rd, rs1, rs2f);
    t.alu_src = 1'b1;
    return t;
  endfunction

  function automatic instr_t mk_load(input logic [4:0] rd, input logic [4:0] rs1);
    instr_t t;
    t = '0;
    t.alu_op = 2'b00; t.alu_src = 1'b1; t.mem_2_reg = 1'b1;
    t.reg_write = 1'b1; t.mem_read = 1'b1;
    t.rd = rd; t.rs1 = rs1;
    return t;
  endfunction

  // Drive one ID bundle just after a rising edge; expected write-back is queued
  // only when the bench expects this instruction to actually enter ID/EX.
  task automatic drive(input instr_t i, input logic flush, input logic push);
    wb_rec_t r;
    @(posedge clk); #1;
    bus.id_alu_op    = i.alu_op;
    bus.id_alu_src   = i.alu_src;
    bus.id_mem_2_reg = i.mem_2_reg;
    bus.id_reg_write = i.reg_write;
    bus.id_mem_read  = i.mem_read;
    bus.id_mem_write = i.mem_write;
    bus.id_branch    = i.branch;
    bus.id_jump      = i.jump;
    bus.id_rs1       = i.rs1;
    bus.id_rs2       = i.rs2;
    bus.id_rd        = i.rd;
    bus.flush_id_ex  = flush;
    if (push) begin
      r.cyc = cyc + 3; r.rw = i.reg_write; r.m2r = i.mem_2_reg; r.rd = i.rd;
      wb_q.push_back(r);
    end
  endtask

  // Write-back scoreboard: every cycle either the queued instruction retires
  // or the WB stage must be silent.
  always @(negedge clk) begin
    wb_rec_t r;
    while (wb_q.size() > 0 && wb_q[0].cyc < cyc) begin
      r = wb_q.pop_front();
      checks++; errors++;
      $display("[TB] FAIL wb_missed: record for cycle %0d never checked (now %0d)", r.cyc, cyc);
    end
    if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
      r = wb_q.pop_front();
      checks++;
      if ({bus.wb_reg_write, bus.wb_mem_2_reg, bus.wb_rd} !== {r.rw, r.m2r, r.rd}) begin
        errors++;
        $display("[TB] FAIL wb_retire cyc %0d: got rw=%b m2r=%b rd=%0d expected rw=%b m2r=%b rd=%0d",
                 cyc, bus.wb_reg_write, bus.wb_mem_2_reg, bus.wb_rd, r.rw, r.m2r, r.rd);
      end
    end else begin
      checks++;
      if ({bus.wb_reg_write, bus.wb_mem_2_reg, bus.wb_rd} !== 7'd0) begin
        errors++;
        $display("[TB] FAIL wb_idle cyc %0d: got rw=%b m2r=%b rd=%0d expected all 0",
                 cyc, bus.wb_reg_write, bus.wb_mem_2_reg, bus.wb_rd);
      end
    end
  end

  task automatic test_reset();
    arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ex_alu_op, bus.ex_alu_src, bus.mem_mem_read, bus.mem_mem_write,
         bus.mem_branch, bus.mem_jump} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {bus.ex_alu_op, bus.ex_alu_src,
               bus.mem_mem_read, bus.mem_mem_write, bus.mem_branch, bus.mem_jump});
    end
    checks++;
    if ({bus.forward_a, bus.forward_b, bus.stall_if_id} !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_fwd_stall: got %b expected 0", {bus.forward_a, bus.forward_b, bus.stall_if_id});
    end
    checks++;
    if (bus.bubble_cnt !== 16'd0 || bus2.bubble_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", bus.bubble_cnt, bus2.bubble_cnt);
    end
    @(posedge clk); #1;
    arst_n = 1'b1;
    exp_bubbles = 0;
  endtask

  task automatic test_forward_alu();
    drive(mk_alu_r(5'd5, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_alu_r(5'd6, 5'd5, 5'd3), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0 || bus.ex_alu_op !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_id: got stall=%b ex_alu_op=%b expected 0/10", bus.stall_if_id, bus.ex_alu_op);
    end
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fwd_exmem: got a=%b b=%b expected a=10 b=00", bus.forward_a, bus.forward_b);
    end
    drive(mk_alu_r(5'd8, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_alu_r(5'd10, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_alu_r(5'd11, 5'd8, 5'd4), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_stall: got %b expected 0", bus.stall_if_id);
    end
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fwd_memwb: got a=%b b=%b expected a=01 b=00", bus.forward_a, bus.forward_b);
    end
  endtask

  task automatic test_load_use();
    drive(mk_load(5'd7, 5'd1), 1'b0, 1'b1);
    drive(mk_alu_r(5'd12, 5'd1, 5'd7), 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b1 || bus.ex_alu_src !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lu_stall: got stall=%b ex_alu_src=%b expected 1/1", bus.stall_if_id, bus.ex_alu_src);
    end
    exp_bubbles++;
    drive(mk_alu_r(5'd12, 5'd1, 5'd7), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0 || bus.ex_alu_op !== 2'b00 || bus.ex_alu_src !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lu_bubble: got stall=%b op=%b src=%b expected 0/00/0",
               bus.stall_if_id, bus.ex_alu_op, bus.ex_alu_src);
    end
    checks++;
    if (bus.bubble_cnt !== 16'(exp_bubbles) || bus.mem_mem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lu_cnt: got cnt=%0d mem_read=%b expected %0d/1", bus.bubble_cnt, bus.mem_mem_read, exp_bubbles);
    end
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b01 || bus.ex_alu_op !== 2'b10) begin
      errors++;
      $display("[TB] FAIL lu_fwd: got a=%b b=%b op=%b expected 00/01/10", bus.forward_a, bus.forward_b, bus.ex_alu_op);
    end
  endtask

  task automatic test_no_hazard();
    drive(mk_load(5'd0, 5'd1), 1'b0, 1'b1);
    drive(mk_alu_r(5'd13, 5'd0, 5'd0), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x0_stall: got %b expected 0", bus.stall_if_id);
    end
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin
      errors++;
      $display("[TB] FAIL x0_fwd: got a=%b b=%b expected 00/00", bus.forward_a, bus.forward_b);
    end
    drive(mk_load(5'd7, 5'd1), 1'b0, 1'b1);
    drive(mk_alu_i(5'd14, 5'd2, 5'd7), 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0 || bus.bubble_cnt !== 16'(exp_bubbles)) begin
      errors++;
      $display("[TB] FAIL itype_stall: got stall=%b cnt=%0d expected 0/%0d", bus.stall_if_id, bus.bubble_cnt, exp_bubbles);
    end
  endtask

  task automatic test_flush_priority();
    drive(mk_load(5'd3, 5'd1), 1'b0, 1'b1);
    drive(mk_alu_r(5'd15, 5'd3, 5'd2), 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.stall_if_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall: got %b expected 0", bus.stall_if_id);
    end
    exp_bubbles++;
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.ex_alu_op !== 2'b00 || bus.bubble_cnt !== 16'(exp_bubbles) || bus.stall_if_id !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_bubble: got op=%b cnt=%0d stall=%b expected 00/%0d/0",
               bus.ex_alu_op, bus.bubble_cnt, bus.stall_if_id, exp_bubbles);
    end
  endtask

  task automatic test_back_to_back();
    drive(mk_alu_r(5'd9, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_alu_r(5'd9, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_alu_r(5'd16, 5'd9, 5'd9), 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b10) begin
      errors++;
      $display("[TB] FAIL fwd_priority: got a=%b b=%b expected 10/10", bus.forward_a, bus.forward_b);
    end
  endtask

  task automatic test_mid_reset();
    drive(mk_alu_r(5'd17, 5'd1, 5'd2), 1'b0, 1'b1);
    drive(mk_load(5'd18, 5'd1), 1'b0, 1'b1);
    drive(mk_alu_r(5'd19, 5'd18, 5'd2), 1'b0, 1'b0);
    arst_n = 1'b0;
    while (wb_q.size() > 0 && wb_q[wb_q.size()-1].cyc > cyc) void'(wb_q.pop_back());
    drive('0, 1'b0, 1'b0);
    arst_n = 1'b1;
    exp_bubbles = 0;
    @(negedge clk);
    checks++;
    if ({bus.ex_alu_op, bus.ex_alu_src, bus.mem_mem_read, bus.mem_mem_write, bus.mem_branch,
         bus.mem_jump, bus.forward_a, bus.forward_b, bus.stall_if_id} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midreset_out: got nonzero outputs %b", {bus.ex_alu_op, bus.ex_alu_src,
               bus.mem_mem_read, bus.mem_mem_write, bus.mem_branch, bus.mem_jump,
               bus.forward_a, bus.forward_b, bus.stall_if_id});
    end
    checks++;
    if (bus.bubble_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midreset_cnt: got %0d expected 0", bus.bubble_cnt);
    end
    repeat (4) drive('0, 1'b0, 1'b1);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(posedge clk); #1;
    bus2.flush_id_ex = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus2.bubble_cnt !== exp_sat[i]) begin
        errors++;
        $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", i, bus2.bubble_cnt, exp_sat[i]);
      end
    end
    bus2.flush_id_ex = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_bubbles = 0;
    arst_n = 1'b0;
    {bus.id_alu_op, bus.id_alu_src, bus.id_mem_2_reg, bus.id_reg_write, bus.id_mem_read,
     bus.id_mem_write, bus.id_branch, bus.id_jump, bus.id_rs1, bus.id_rs2, bus.id_rd,
     bus.flush_id_ex} = '0;
    {bus2.id_alu_op, bus2.id_alu_src, bus2.id_mem_2_reg, bus2.id_reg_write, bus2.id_mem_read,
     bus2.id_mem_write, bus2.id_branch, bus2.id_jump, bus2.id_rs1, bus2.id_rs2, bus2.id_rd,
     bus2.flush_id_ex} = '0;

    test_reset();
    test_forward_alu();
    test_load_use();
    test_no_hazard();
    test_flush_priority();
    test_back_to_back();
    test_mid_reset();
    repeat (4) drive('0, 1'b0, 1'b1);
    test_saturation();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wb_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL wb_drain: got %0d pending records expected 0", wb_q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
